// File: rtl/cpu_pkg.sv
// Shared constants, stage record and instruction ROM contents for the
// nine-stage R-type MIPS pipeline.
package cpu_pkg;
    localparam int DATA_W     = 32;
    localparam int NUM_STAGES = 9;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_XOR    = 6'h26;
    localparam logic [5:0] F_NOR    = 6'h27;
    localparam logic [5:0] F_SLT    = 6'h2a;
    localparam logic [5:0] F_SLTU   = 6'h2b;

    // One execute/writeback pipeline slot; we already folds in decode legality.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } stage_t;

    function automatic logic [31:0] r_type(input logic [5:0] funct,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs,
                                           input logic [4:0] rt);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        logic [31:0] w;
        w = '0;
        case (idx)
            32'd0:   w = r_type(F_ADD,  5'd31, 5'd1,  5'd2);
            32'd1:   w = r_type(F_ADDU, 5'd30, 5'd3,  5'd4);
            32'd2:   w = r_type(F_AND,  5'd29, 5'd5,  5'd6);
            32'd3:   w = r_type(F_NOR,  5'd28, 5'd7,  5'd8);
            32'd4:   w = r_type(F_OR,   5'd27, 5'd9,  5'd10);
            32'd5:   w = r_type(F_SLT,  5'd26, 5'd11, 5'd12);
            32'd6:   w = r_type(F_SLTU, 5'd25, 5'd14, 5'd13);
            32'd7:   w = r_type(F_SUB,  5'd24, 5'd15, 5'd16);
            32'd8:   w = r_type(F_SUBU, 5'd23, 5'd17, 5'd18);
            32'd9:   w = r_type(F_XOR,  5'd22, 5'd19, 5'd20);
            default: w = '0;
        endcase
        return w;
    endfunction
endpackage

// File: rtl/cpu_if.sv
// Writeback and register-file observation bundle driven by cpu_top.
interface cpu_if;
    import cpu_pkg::*;

    logic              regfile_we;
    logic [DATA_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_writedata;
    logic [DATA_W-1:0] rf [REG_COUNT];

    modport master (output regfile_we, rd_addr, rd_writedata, rf);
    modport slave  (input  regfile_we, rd_addr, rd_writedata, rf);
endinterface

// File: rtl/cpu_alu.sv
// Combinational R-type ALU selected by funct; legal flags supported functs.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] result,
    output logic              legal
);
    always_comb begin
        result = '0;
        legal  = 1'b1;
        case (funct)
            F_ADD, F_ADDU: result = a + b;
            F_SUB, F_SUBU: result = a - b;
            F_AND:         result = a & b;
            F_OR:          result = a | b;
            F_XOR:         result = a ^ b;
            F_NOR:         result = ~(a | b);
            F_SLT:         result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU:        result = {{(DATA_W-1){1'b0}}, (a < b)};
            default:       legal  = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_top.sv
// Stall-free IF1-IF2-IF3-ID-EX1..EXn-WB pipeline running a fixed ROM program
// with no forwarding; writeback and the register file are visible on probe.
module cpu_top
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES = 9,
    parameter int IMEM_WORDS = 16
) (
    input  logic clk,
    input  logic rst,
    output logic dummy,
    cpu_if.master probe
);
    localparam int EX_STAGES = NUM_STAGES - 5;
    localparam int PC_IDX_W  = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [PC_IDX_W-1:0] LAST_IDX = PC_IDX_W'(IMEM_WORDS - 1);

    logic [DATA_W-1:0]   pc_reg;
    logic [DATA_W-1:0]   pc_next;
    logic [PC_IDX_W-1:0] pc_idx;

    logic                if1_valid_reg;
    logic [PC_IDX_W-1:0] if1_idx_reg;
    logic                if2_valid_reg;
    logic [31:0]         if2_instr_reg;
    logic                if3_valid_reg;
    logic [31:0]         if3_instr_reg;

    logic                  id_valid_reg;
    logic                  id_rtype_reg;
    logic [5:0]            id_funct_reg;
    logic [REG_ADDR_W-1:0] id_rd_reg;
    logic [DATA_W-1:0]     id_a_reg;
    logic [DATA_W-1:0]     id_b_reg;

    logic [DATA_W-1:0] alu_result;
    logic              alu_legal;
    stage_t            ex1_next;
    stage_t            ex_reg [EX_STAGES];
    stage_t            wb_reg;

    logic [DATA_W-1:0] rf_reg [REG_COUNT];

    assign pc_idx  = pc_reg[PC_IDX_W+1:2];
    assign pc_next = (pc_idx == LAST_IDX) ? '0 : pc_reg + DATA_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg        <= '0;
            if1_valid_reg <= 1'b0;
            if1_idx_reg   <= '0;
            if2_valid_reg <= 1'b0;
            if2_instr_reg <= '0;
            if3_valid_reg <= 1'b0;
            if3_instr_reg <= '0;
            id_valid_reg  <= 1'b0;
            id_rtype_reg  <= 1'b0;
            id_funct_reg  <= '0;
            id_rd_reg     <= '0;
            id_a_reg      <= '0;
            id_b_reg      <= '0;
        end else begin
            pc_reg        <= pc_next;
            if1_idx_reg   <= pc_idx;
            if1_valid_reg <= 1'b1;
            if2_instr_reg <= rom_word(DATA_W'(if1_idx_reg));
            if2_valid_reg <= if1_valid_reg;
            if3_instr_reg <= if2_instr_reg;
            if3_valid_reg <= if2_valid_reg;
            // Operands come straight from the register file: no bypass paths.
            id_valid_reg  <= if3_valid_reg;
            id_rtype_reg  <= (if3_instr_reg[31:26] == OP_RTYPE) && (if3_instr_reg[10:6] == 5'd0);
            id_funct_reg  <= if3_instr_reg[5:0];
            id_rd_reg     <= if3_instr_reg[15:11];
            id_a_reg      <= rf_reg[if3_instr_reg[25:21]];
            id_b_reg      <= rf_reg[if3_instr_reg[20:16]];
        end
    end

    cpu_alu u_alu (
        .a      (id_a_reg),
        .b      (id_b_reg),
        .funct  (id_funct_reg),
        .result (alu_result),
        .legal  (alu_legal)
    );

    always_comb begin
        ex1_next       = '0;
        ex1_next.valid = id_valid_reg;
        ex1_next.we    = id_valid_reg && id_rtype_reg && alu_legal && (id_rd_reg != '0);
        ex1_next.rd    = id_rd_reg;
        ex1_next.data  = alu_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EX_STAGES; i++) begin
                ex_reg[i] <= '0;
            end
            wb_reg <= '0;
        end else begin
            ex_reg[0] <= ex1_next;
            for (int i = 1; i < EX_STAGES; i++) begin
                ex_reg[i] <= ex_reg[i-1];
            end
            wb_reg <= ex_reg[EX_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_reg[i] <= DATA_W'(i);
            end
        end else if (wb_reg.valid && wb_reg.we && (wb_reg.rd != '0)) begin
            rf_reg[wb_reg.rd] <= wb_reg.data;
        end
    end

    assign dummy              = ^wb_reg.data;
    assign probe.regfile_we   = wb_reg.valid & wb_reg.we;
    assign probe.rd_addr      = {{(DATA_W-REG_ADDR_W){1'b0}}, wb_reg.rd};
    assign probe.rd_writedata = wb_reg.data;

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_rf_probe
        assign probe.rf[gi] = rf_reg[gi];
    end
endmodule

// File: tb/tb_cpu_top.sv
// Scoreboard bench: a program-level model predicts every register write and
// its cycle; a negedge monitor pops and compares. The ALU is also spot-checked.
module tb_cpu_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dummy;

    cpu_if probe_if();

    cpu_top #(.NUM_STAGES(9), .IMEM_WORDS(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .dummy (dummy),
        .probe (probe_if)
    );

    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_funct;
    logic        alu_legal;

    cpu_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .funct  (alu_funct),
        .result (alu_result),
        .legal  (alu_legal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          rd;
        logic [31:0] data;
        int          cycle;
    } exp_t;
    exp_t exp_q[$];

    int p_f [10] = '{'h20, 'h21, 'h24, 'h27, 'h25, 'h2a, 'h2b, 'h22, 'h23, 'h26};
    int p_rd[10] = '{31, 30, 29, 28, 27, 26, 25, 24, 23, 22};
    int p_rs[10] = '{1, 3, 5, 7, 9, 11, 14, 15, 17, 19};
    int p_rt[10] = '{2, 4, 6, 8, 10, 12, 13, 16, 18, 20};

    logic [31:0] m_rf [32];

    function automatic logic [31:0] ref_op(int f, logic [31:0] a, logic [31:0] b);
        case (f)
            'h20, 'h21: return a + b;
            'h22, 'h23: return a - b;
            'h24:       return a & b;
            'h25:       return a | b;
            'h26:       return a ^ b;
            'h27:       return ~(a | b);
            'h2a:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            'h2b:       return (a < b) ? 32'd1 : 32'd0;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic bit ref_legal(int f);
        for (int k = 0; k < 10; k++) begin
            if (p_f[k] == f) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    task automatic check_reset_state();
        @(negedge clk); #1;
        check("rst_regfile_we", {31'b0, probe_if.regfile_we}, 32'd0);
        check("rst_dummy", {31'b0, dummy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rst_rf%0d", i), probe_if.rf[i], 32'(i));
        end
    endtask

    // The fetch PC wraps every 16 words, so the program re-runs with the
    // same operands; every fetch inside the observation window is predicted.
    task automatic start_program(int window);
        int rel;
        logic [31:0] res;
        rel = cyc;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
        for (int n = 1; n + 8 <= window; n++) begin
            int w;
            w = (n - 1) % 16;
            if (w < 10) begin
                res = ref_op(p_f[w], m_rf[p_rs[w]], m_rf[p_rt[w]]);
                exp_q.push_back('{rd: p_rd[w], data: res, cycle: rel + n + 8});
                if (p_rd[w] != 0) m_rf[p_rd[w]] = res;
            end
        end
        rst = 1'b0;
    endtask

    task automatic check_window_end();
        check("pending_writes", exp_q.size(), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("final_rf%0d", i), probe_if.rf[i], m_rf[i]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && probe_if.regfile_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: rd=%0d data=0x%08h cycle=%0d, required no write",
                         probe_if.rd_addr, probe_if.rd_writedata, cyc);
            end else begin
                e = exp_q.pop_front();
                $display("write rd=%0d data=0x%08h cycle=%0d", probe_if.rd_addr, probe_if.rd_writedata, cyc);
                check("wb_rd", probe_if.rd_addr, 32'(e.rd));
                check("wb_data", probe_if.rd_writedata, e.data);
                check("wb_cycle", 32'(cyc), 32'(e.cycle));
                check("wb_dummy", {31'b0, dummy}, {31'b0, ^e.data});
            end
        end
    end

    initial begin
        alu_a = '0;
        alu_b = '0;
        alu_funct = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_state();

        @(negedge clk); #1;
        start_program(50);
        repeat (50) @(posedge clk);
        @(negedge clk); #1;
        check_window_end();

        rst = 1'b1;
        check_reset_state();

        // Abort the program in cycle 5, before any write commits.
        @(negedge clk); #1;
        start_program(50);
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        check_reset_state();

        @(negedge clk); #1;
        start_program(50);
        repeat (50) @(posedge clk);
        @(negedge clk); #1;
        check_window_end();

        alu_a = 32'hffff_ffff; alu_b = 32'd1; alu_funct = 6'h2b; #1;
        check("alu_sltu_boundary", alu_result, 32'd0);
        alu_funct = 6'h2a; #1;
        check("alu_slt_boundary", alu_result, 32'd1);
        alu_a = 32'h8000_0000; alu_b = 32'h7fff_ffff; alu_funct = 6'h20; #1;
        check("alu_add_wrap", alu_result, 32'hffff_ffff);
        alu_a = 32'd0; alu_b = 32'd1; alu_funct = 6'h23; #1;
        check("alu_subu_wrap", alu_result, 32'hffff_ffff);

        for (int k = 0; k < 60; k++) begin
            int f;
            if (k % 6 == 5) f = int'($urandom_range(0, 63));
            else f = p_f[$urandom_range(0, 9)];
            alu_funct = 6'(f);
            alu_a = (k % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            alu_b = (k % 4 == 1) ? 32'hffff_fffe + 32'($urandom_range(0, 1)) : $urandom;
            #1;
            $display("alu funct=0x%02h a=0x%08h b=0x%08h -> 0x%08h legal=%0d",
                     alu_funct, alu_a, alu_b, alu_result, alu_legal);
            check("alu_legal", {31'b0, alu_legal}, {31'b0, ref_legal(f)});
            if (ref_legal(f)) check("alu_result", alu_result, ref_op(f, alu_a, alu_b));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
